// File: rtl/wave_synth_if.sv
// wave_synth_if: control and sample bundle between the function-generator
// controller (master) and the wave_synth DDS core (slave).
// The sync member and its modport entries exist only when
// WAVE_SYNTH_SYNC_EN is defined.
interface wave_synth_if #(
    parameter int DATA_W  = 12,
    parameter int PHASE_W = 24
);
    logic               enable;
    logic [1:0]         mode;
    logic [PHASE_W-1:0] phase_inc;
    logic [DATA_W-1:0]  maximum;
    logic [DATA_W-1:0]  minimum;
    logic [DATA_W-1:0]  waveform;
    logic               valid;
`ifdef WAVE_SYNTH_SYNC_EN
    logic               sync;

    modport master (
        output enable, mode, phase_inc, maximum, minimum,
        input  waveform, valid, sync
    );
    modport slave (
        input  enable, mode, phase_inc, maximum, minimum,
        output waveform, valid, sync
    );
`else
    modport master (
        output enable, mode, phase_inc, maximum, minimum,
        input  waveform, valid
    );
    modport slave (
        input  enable, mode, phase_inc, maximum, minimum,
        output waveform, valid
    );
`endif
endinterface

// File: rtl/wave_synth.sv
// wave_synth: direct-digital-synthesis waveform generator.
// A phase accumulator selects a sine table entry or an arithmetic shape
// (square, triangle, sawtooth); the shape is scaled into [minimum, maximum].
// Pipeline: acc (n) -> shape register with synchronous table read (n+1)
//           -> scaled waveform register (n+2).
// Optional feature macro: WAVE_SYNTH_SYNC_EN adds the start-of-period sync
// pulse, aligned with the first post-wrap sample on waveform.
// Parameter constraint: PHASE_W >= DATA_W and PHASE_W >= LUT_AW.
module wave_synth #(
    parameter int DATA_W  = 12,
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    wave_synth_if.slave bus
);

    localparam int    LUT_DEPTH = 1 << LUT_AW;
    localparam int    PROD_W    = 2 * DATA_W + 1;
    localparam real   PI        = 3.14159265358979323846;

    typedef enum logic [1:0] {
        SHAPE_SINE     = 2'd0,
        SHAPE_SQUARE   = 2'd1,
        SHAPE_TRIANGLE = 2'd2,
        SHAPE_SAW      = 2'd3
    } shape_e;

    // Sine table entry k: round((2^DATA_W-1) * (1 + sin(2*pi*k/DEPTH)) / 2).
    function automatic logic [DATA_W-1:0] sine_entry(input int k);
        real full_scale;
        real angle;
        real value;
        full_scale = (2.0 ** DATA_W) - 1.0;
        angle      = 2.0 * PI * real'(k) / real'(LUT_DEPTH);
        value      = full_scale * (1.0 + $sin(angle)) / 2.0;
        return DATA_W'($rtoi(value + 0.5));
    endfunction

    // ------------------------------------------------------------------
    // Phase accumulator
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W-1:0] acc_d;
    logic               wrap;

    // Next phase and carry out; the carry marks the start of a new period.
    always_comb begin
        {wrap, acc_d} = {1'b0, acc_q} + {1'b0, bus.phase_inc};
    end

    // Accumulator advances only on enabled cycles; phase is held otherwise.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (bus.enable) begin
            acc_q <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers for mode and output window
    // ------------------------------------------------------------------
    shape_e             mode_q;
    logic [DATA_W-1:0]  max_q;
    logic [DATA_W-1:0]  min_q;
    logic               shadow_load;

    // While running, new settings wait for the period boundary so a period is
    // never split between two shapes or windows; while idle they track freely.
    assign shadow_load = !bus.enable || wrap;

    // Shadow capture of mode/maximum/minimum.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= SHAPE_SINE;
            max_q  <= '0;
            min_q  <= '0;
        end else if (shadow_load) begin
            mode_q <= shape_e'(bus.mode);
            max_q  <= bus.maximum;
            min_q  <= bus.minimum;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: shape generation and window preparation
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  sine_lut [LUT_DEPTH];
    logic [DATA_W-1:0]  t;
    logic [LUT_AW-1:0]  lut_addr;
    logic [DATA_W-1:0]  s_d;
    logic [DATA_W-1:0]  span_d;
    logic [DATA_W-1:0]  s_q;
    logic [DATA_W-1:0]  span_q;
    logic [DATA_W-1:0]  base_q;
    logic               v1_q;

    // NOTE: the sine table is a constant ROM computed at elaboration; it has
    // no reset and no write port, only the registered read in stage 1.
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_sine_lut
        assign sine_lut[k] = sine_entry(k);
    end

    assign t        = acc_q[PHASE_W-1 -: DATA_W];
    assign lut_addr = acc_q[PHASE_W-1 -: LUT_AW];

    // Shape select from the current phase and the shadowed mode.
    // NOTE: s_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        s_d = '0;
        case (mode_q)
            SHAPE_SINE:     s_d = sine_lut[lut_addr];
            SHAPE_SQUARE:   s_d = t[DATA_W-1] ? '0 : '1;
            SHAPE_TRIANGLE: s_d = t[DATA_W-1] ? ~(t << 1) : (t << 1);
            SHAPE_SAW:      s_d = t;
        endcase
    end

    // An inverted window collapses to zero span, i.e. a constant minimum.
    assign span_d = (max_q >= min_q) ? (max_q - min_q) : '0;

    // Stage 1 register: shape (synchronous table read) plus the window that
    // belongs to this sample, so a window change lines up with its period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_q    <= '0;
            span_q <= '0;
            base_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= bus.enable;
            if (bus.enable) begin
                s_q    <= s_d;
                span_q <= span_d;
                base_q <= min_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: scaling into [minimum, maximum]
    // ------------------------------------------------------------------
    logic [PROD_W-1:0]  prod;
    logic [DATA_W-1:0]  wave_d;
    logic [DATA_W-1:0]  waveform_q;
    logic               valid_q;

    // (span*s + span) >> DATA_W maps s=0 to 0 and s=full-scale to span
    // exactly, so minimum + scaled never exceeds maximum.
    always_comb begin
        prod   = PROD_W'(span_q) * PROD_W'(s_q) + PROD_W'(span_q);
        wave_d = base_q + DATA_W'(prod >> DATA_W);
    end

    // Output register; holds the last sample when no new one arrives.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            waveform_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= v1_q;
            if (v1_q) begin
                waveform_q <= wave_d;
            end
        end
    end

    assign bus.waveform = waveform_q;
    assign bus.valid    = valid_q;

`ifdef WAVE_SYNTH_SYNC_EN
    // ------------------------------------------------------------------
    // Start-of-period marker, carried alongside the sample it belongs to
    // ------------------------------------------------------------------
    logic start_q;
    logic start1_q;
    logic sync_q;

    // start_q flags that acc_q holds the first phase of a new period; it
    // follows the sample through the same enables as the data path.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_q  <= 1'b0;
            start1_q <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            if (bus.enable) begin
                start_q  <= wrap;
                start1_q <= start_q;
            end
            sync_q <= v1_q && start1_q;
        end
    end

    assign bus.sync = sync_q;
`endif

endmodule

// File: tb/tb_wave_synth.sv
// tb_wave_synth: directed stimulus for wave_synth with a scoreboard.
// A spec-level model predicts each sample when the DUT samples an enabled
// cycle; predictions are popped and compared when valid is seen.
// Define WAVE_SYNTH_SYNC_EN for both RTL and bench to check the sync pulse.
module tb_wave_synth;

    localparam int DATA_W  = 12;
    localparam int PHASE_W = 24;
    localparam int LUT_AW  = 8;
    localparam real PI     = 3.141592653589793;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    wave_synth_if #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) bus ();

    wave_synth #(
        .DATA_W (DATA_W),
        .PHASE_W(PHASE_W),
        .LUT_AW (LUT_AW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        int   wave;
        logic sync;
    } sample_t;

    sample_t       exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    // Model state
    logic [23:0]   m_acc;
    logic [1:0]    m_mode;
    int            m_min;
    int            m_max;
    logic          m_start;
    int            last_wave;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected sample from the shape definitions and scaling rule.
    function automatic int model_wave(input logic [1:0] md, input int lo,
                                      input int hi, input logic [23:0] acc);
        int  tt;
        int  s;
        int  span;
        int  idx;
        real v;
        tt  = int'(acc[23:12]);
        idx = int'(acc[23:16]);
        case (md)
            2'd0: begin
                v = 4095.0 * (1.0 + $sin(2.0 * PI * real'(idx) / 256.0)) / 2.0;
                s = $rtoi(v + 0.5);
            end
            2'd1:    s = (tt >= 2048) ? 0 : 4095;
            2'd2:    s = (tt < 2048) ? 2 * tt : 4095 - ((2 * tt) % 4096);
            default: s = tt;
        endcase
        span = (hi >= lo) ? hi - lo : 0;
        return lo + ((span * s + span) >> 12);
    endfunction

    task automatic model_reset();
        m_acc     = '0;
        m_mode    = 2'd0;
        m_min     = 0;
        m_max     = 0;
        m_start   = 1'b0;
        last_wave = 0;
        exp_q.delete();
    endtask

    // One clock: update the model with the inputs the DUT samples, then
    // check the outputs at the falling edge.
    task automatic tick();
        sample_t     e;
        logic        wr;
        logic [24:0] sum;
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            wr = 1'b0;
            if (bus.enable) begin
                e.wave = model_wave(m_mode, m_min, m_max, m_acc);
                e.sync = m_start;
                exp_q.push_back(e);
                sum     = {1'b0, m_acc} + {1'b0, bus.phase_inc};
                wr      = sum[24];
                m_acc   = sum[23:0];
                m_start = wr;
            end
            if (!bus.enable || wr) begin
                m_mode = bus.mode;
                m_min  = int'(bus.minimum);
                m_max  = int'(bus.maximum);
            end
        end
        @(negedge clock);
        if (bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("waveform", bus.waveform, e.wave);
`ifdef WAVE_SYNTH_SYNC_EN
                check("sync", bus.sync, e.sync);
`endif
                last_wave = e.wave;
            end
        end else begin
            check("valid_low", bus.valid, 0);
            check("hold", bus.waveform, last_wave);
`ifdef WAVE_SYNTH_SYNC_EN
            check("sync_idle", bus.sync, 0);
`endif
        end
    endtask

    // Run until the model's next sample index within the period equals p.
    task automatic run_to_phase(input int p);
        for (int i = 0; i < 300 && int'(m_acc[23:16]) != p; i++) begin
            tick();
        end
    endtask

    initial begin
        model_reset();
        reset_n       = 1'b0;
        bus.enable    = 1'b0;
        bus.mode      = 2'd0;
        bus.phase_inc = '0;
        bus.maximum   = '0;
        bus.minimum   = '0;

        // Reset state
        repeat (3) tick();
        check("reset_acc", dut.acc_q, 0);
        check("reset_wave", bus.waveform, 0);
        check("reset_valid", bus.valid, 0);

        // Sawtooth full scale, enable from reset
        reset_n       = 1'b1;
        bus.mode      = 2'd3;
        bus.minimum   = 12'd0;
        bus.maximum   = 12'd4095;
        bus.phase_inc = 24'h010000;
        tick();
        bus.enable = 1'b1;
        tick();
        check("valid_lat1", bus.valid, 0);
        tick();
        check("valid_lat2", bus.valid, 1);
        check("first_sample", bus.waveform, 0);
        repeat (600) tick();

        // Mid-period mode switch sawtooth -> triangle
        run_to_phase(100);
        bus.mode = 2'd2;
        repeat (400) tick();

        // Mid-period window change
        run_to_phase(60);
        bus.minimum = 12'd200;
        bus.maximum = 12'd3800;
        repeat (300) tick();

        // Square in [100, 3000]
        run_to_phase(30);
        bus.mode    = 2'd1;
        bus.minimum = 12'd100;
        bus.maximum = 12'd3000;
        repeat (600) tick();

        // Sine full scale
        run_to_phase(10);
        bus.mode    = 2'd0;
        bus.minimum = 12'd0;
        bus.maximum = 12'd4095;
        repeat (520) tick();

        // Enable low: outputs hold, no sync
        bus.enable = 1'b0;
        repeat (12) tick();

        // Inverted window gives constant minimum in every mode
        for (int m = 0; m < 4; m++) begin
            bus.enable  = 1'b0;
            bus.mode    = 2'(m);
            bus.maximum = 12'd500;
            bus.minimum = 12'd900;
            tick();
            bus.enable = 1'b1;
            repeat (40) tick();
            check("inverted_const", bus.waveform, 900);
        end

        // Zero phase step: constant sample
        bus.enable    = 1'b0;
        bus.mode      = 2'd3;
        bus.minimum   = 12'd0;
        bus.maximum   = 12'd4095;
        bus.phase_inc = '0;
        tick();
        bus.enable = 1'b1;
        repeat (20) tick();

        // Non-aligned phase step through triangle and sawtooth
        bus.phase_inc = 24'h123457;
        bus.mode      = 2'd2;
        repeat (100) tick();
        bus.mode = 2'd3;
        repeat (100) tick();

        // Asynchronous reset mid-period, then restart from zero
        bus.enable    = 1'b0;
        bus.phase_inc = 24'h010000;
        tick();
        bus.enable = 1'b1;
        repeat (50) tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_wave", bus.waveform, 0);
        check("async_rst_valid", bus.valid, 0);
        check("async_rst_acc", dut.acc_q, 0);
        model_reset();
        bus.enable = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        bus.enable = 1'b1;
        tick();
        tick();
        check("restart_valid", bus.valid, 1);
        check("restart_first", bus.waveform, 0);
        repeat (20) tick();

        // Drain the pipeline; every prediction must have been consumed
        bus.enable = 1'b0;
        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
